// File: rtl/pipe_stage_reg_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the generic pipeline stage register:
//   DATA_W / ADDR_W / TNEW_W  default field widths of one slice
//   RESET_PC                  PC carried by reset values and bubbles
//   slice_t                   one pipeline slice {valid,pc,data,wa,we,tnew}
//   BUBBLE                    an empty slice
//   tnew_dec()                saturating Tnew countdown
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam int          DATA_W   = 32;
  localparam int          ADDR_W   = 5;
  localparam int          TNEW_W   = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  typedef struct packed {
    logic              valid;
    logic [31:0]       pc;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] wa;
    logic              we;
    logic [TNEW_W-1:0] tnew;
  } slice_t;

  localparam slice_t BUBBLE = '{
    valid: 1'b0,
    pc:    RESET_PC,
    data:  '0,
    wa:    '0,
    we:    1'b0,
    tnew:  '0
  };

  // Counts down towards zero and then sticks there; never wraps.
  function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] cur);
    return (cur == '0) ? '0 : cur - 1'b1;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg_if
// Bundle between the upstream stage / hazard unit and a pipe_stage_reg.
//   master : drives stall, flush, in_*, q_addr; observes out_*, q_hit, q_ready
//   slave  : the stage register itself
// ---------------------------------------------------------------------------
interface pipe_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int TNEW_W = 2
);

  logic              stall;
  logic              flush;
  logic              in_valid;
  logic [31:0]       in_pc;
  logic [DATA_W-1:0] in_data;
  logic [ADDR_W-1:0] in_wa;
  logic              in_we;
  logic [TNEW_W-1:0] in_tnew;
  logic              out_valid;
  logic [31:0]       out_pc;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_wa;
  logic              out_we;
  logic [TNEW_W-1:0] out_tnew;
  logic [ADDR_W-1:0] q_addr;
  logic              q_hit;
  logic              q_ready;

  modport master (
    output stall, flush, in_valid, in_pc, in_data, in_wa, in_we, in_tnew, q_addr,
    input  out_valid, out_pc, out_data, out_wa, out_we, out_tnew, q_hit, q_ready
  );

  modport slave (
    input  stall, flush, in_valid, in_pc, in_data, in_wa, in_we, in_tnew, q_addr,
    output out_valid, out_pc, out_data, out_wa, out_we, out_tnew, q_hit, q_ready
  );

endinterface

// File: rtl/pipe_stage_reg_slice.sv
// ---------------------------------------------------------------------------
// pipe_slice
// One register slice of the pipeline stage.
//   clk    clock
//   reset  synchronous, active-low; loads a bubble (beats stall and flush)
//   stall  hold contents; tnew still counts down
//   flush  load a bubble regardless of stall
//   d      slice presented at the input
//   q      registered slice
// ---------------------------------------------------------------------------
module pipe_slice
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = pipe_pkg::RESET_PC
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   stall,
  input  logic   flush,
  input  slice_t d,
  output slice_t q
);

  slice_t bubble;
  slice_t loaded;
  slice_t slice_reg;
  slice_t slice_next;

  always_comb begin
    bubble    = BUBBLE;
    bubble.pc = RESET_PC;

    // A non-valid instruction must never look like a pending writer.
    loaded      = d;
    loaded.we   = d.valid & d.we;
    loaded.tnew = d.valid ? tnew_dec(d.tnew) : '0;

    // Hold: everything frozen except the result-ready countdown.
    slice_next      = slice_reg;
    slice_next.tnew = tnew_dec(slice_reg.tnew);

    if (flush) begin
      slice_next = bubble;
    end else if (!stall) begin
      slice_next = loaded;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      slice_reg <= bubble;
    end else begin
      slice_reg <= slice_next;
    end
  end

  assign q = slice_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
// Generic pipeline stage register: DEPTH chained slices carrying PC, payload,
// write-back descriptor and Tnew, with stall/flush and a forwarding query.
//   clk    clock
//   reset  synchronous, active-low
//   bus    pipe_stage_reg_if.slave: stall, flush, in_*, q_addr in;
//          out_*, q_hit, q_ready out (out_we/q_hit/q_ready combinational)
// ---------------------------------------------------------------------------
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int          DATA_W   = pipe_pkg::DATA_W,
  parameter int          ADDR_W   = pipe_pkg::ADDR_W,
  parameter int          TNEW_W   = pipe_pkg::TNEW_W,
  parameter int          DEPTH    = 1,
  parameter logic [31:0] RESET_PC = pipe_pkg::RESET_PC
) (
  input  logic             clk,
  input  logic             reset,
  pipe_stage_reg_if.slave  bus
);

  // stage[0] is the input; stage[gi+1] is the output of slice gi.
  slice_t stage [DEPTH+1];
  slice_t last;

  assign stage[0] = '{
    valid: bus.in_valid,
    pc:    bus.in_pc,
    data:  bus.in_data,
    wa:    bus.in_wa,
    we:    bus.in_we,
    tnew:  bus.in_tnew
  };

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slice
      // Only the entry slice is flushed; later slices drain normally.
      pipe_slice #(
        .RESET_PC (RESET_PC)
      ) u_slice (
        .clk   (clk),
        .reset (reset),
        .stall (bus.stall),
        .flush ((gi == 0) ? bus.flush : 1'b0),
        .d     (stage[gi]),
        .q     (stage[gi+1])
      );
    end
  endgenerate

  assign last = stage[DEPTH];

  assign bus.out_valid = last.valid;
  assign bus.out_pc    = last.pc;
  assign bus.out_data  = last.data;
  assign bus.out_wa    = last.wa;
  assign bus.out_tnew  = last.tnew;

  // r0 is hard-wired zero, so a write to it is never a forwarding source.
  assign bus.out_we  = last.valid & last.we & (last.wa != '0);
  assign bus.q_hit   = bus.out_we & (last.wa == bus.q_addr) & (bus.q_addr != '0);
  assign bus.q_ready = bus.q_hit & (last.tnew == '0);

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  pipe_stage_reg_if #(.DATA_W(32), .ADDR_W(5), .TNEW_W(2)) bus1 ();
  pipe_stage_reg_if #(.DATA_W(32), .ADDR_W(5), .TNEW_W(2)) bus3 ();

  pipe_stage_reg #(.DEPTH(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  pipe_stage_reg #(.DEPTH(3)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // One clock edge; returns 1 ns after it so outputs are settled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic v, input logic [31:0] pc, input logic [4:0] wa,
                        input logic we, input logic [1:0] tn, input logic [31:0] dt);
    bus1.in_valid = v;  bus1.in_pc = pc; bus1.in_wa = wa;
    bus1.in_we    = we; bus1.in_tnew = tn; bus1.in_data = dt;
  endtask

  task automatic drive3(input logic v, input logic [31:0] pc, input logic [4:0] wa,
                        input logic we, input logic [1:0] tn, input logic [31:0] dt);
    bus3.in_valid = v;  bus3.in_pc = pc; bus3.in_wa = wa;
    bus3.in_we    = we; bus3.in_tnew = tn; bus3.in_data = dt;
  endtask

  // Stream schedule for DEPTH=3: per edge, stall and expected output after it.
  logic        s_stall [9] = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
  logic        s_valid [9] = '{0, 0, 1, 1, 1, 1, 1, 1, 0};
  logic [31:0] s_pc    [9] = '{0, 0, 32'h3000, 32'h3000, 32'h3004, 32'h3008,
                               32'h300C, 32'h3010, 0};

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    bus1.stall = 0; bus1.flush = 0; bus1.q_addr = 0;
    bus3.stall = 0; bus3.flush = 0; bus3.q_addr = 0;
    drive1(0, 32'h0, 0, 0, 0, 0);
    drive3(0, 32'h0, 0, 0, 0, 0);

    // 1. reset, then first injection on DEPTH=1
    step(); step();
    check("rst_valid",  32'(bus1.out_valid), 32'd0);
    check("rst_pc",     bus1.out_pc,         32'h3000);
    check("rst_tnew",   32'(bus1.out_tnew),  32'd0);
    check("rst_we",     32'(bus1.out_we),    32'd0);
    check("rst3_valid", 32'(bus3.out_valid), 32'd0);
    check("rst3_pc",    bus3.out_pc,         32'h3000);
    reset = 1'b1;
    drive1(1, 32'h3004, 5'd8, 1, 2'd2, 32'hA5A5_0001);
    step();
    check("inj_valid", 32'(bus1.out_valid), 32'd1);
    check("inj_pc",    bus1.out_pc,         32'h3004);
    check("inj_we",    32'(bus1.out_we),    32'd1);
    check("inj_tnew",  32'(bus1.out_tnew),  32'd1);
    check("inj_data",  bus1.out_data,       32'hA5A5_0001);
    check("inj_wa",    32'(bus1.out_wa),    32'd8);
    bus1.q_addr = 5'd8;
    #1;
    check("inj_qhit",   32'(bus1.q_hit),   32'd1);
    check("inj_qready", 32'(bus1.q_ready), 32'd0);

    // 2. stall three cycles: frozen, tnew saturates at 0
    drive1(1, 32'h3FFC, 5'd3, 1, 2'd3, 32'h0);
    bus1.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall%0d_pc", i),   bus1.out_pc,        32'h3004);
      check($sformatf("stall%0d_tnew", i), 32'(bus1.out_tnew), 32'd0);
    end
    check("stall_qready", 32'(bus1.q_ready), 32'd1);
    bus1.q_addr = 5'd9;
    #1;
    check("stall_qhit_miss", 32'(bus1.q_hit), 32'd0);

    // 3. stall and flush on the same edge
    bus1.flush = 1'b1;
    step();
    check("flush_valid", 32'(bus1.out_valid), 32'd0);
    check("flush_we",    32'(bus1.out_we),    32'd0);
    check("flush_pc",    bus1.out_pc,         32'h3000);
    bus1.flush = 1'b0;
    bus1.stall = 1'b0;

    // 4. write to r0 never qualifies
    drive1(1, 32'h3008, 5'd0, 1, 2'd0, 32'h1234);
    step();
    bus1.q_addr = 5'd0;
    #1;
    check("r0_valid", 32'(bus1.out_valid), 32'd1);
    check("r0_we",    32'(bus1.out_we),    32'd0);
    check("r0_qhit",  32'(bus1.q_hit),     32'd0);
    // invalid instruction: we and tnew forced to 0
    drive1(0, 32'h300C, 5'd7, 1, 2'd3, 32'h0);
    step();
    check("inv_we",   32'(bus1.out_we),   32'd0);
    check("inv_tnew", 32'(bus1.out_tnew), 32'd0);
    // tnew=0 stays 0 and is immediately ready
    drive1(1, 32'h3010, 5'd5, 1, 2'd0, 32'h0);
    bus1.q_addr = 5'd5;
    step();
    check("t0_tnew",   32'(bus1.out_tnew), 32'd0);
    check("t0_qready", 32'(bus1.q_ready),  32'd1);
    drive1(0, 32'h0, 0, 0, 0, 0);

    // 5. DEPTH=3 stream with a one-cycle stall on the 4th edge
    begin
      int idx;
      idx = 0;
      for (int e = 0; e < 9; e++) begin
        if (idx < 5)
          drive3(1, 32'h3000 + 32'(idx) * 4, 5'(idx + 1), 1, 2'd3, 32'(idx));
        else
          drive3(0, 32'h0, 0, 0, 0, 0);
        bus3.stall = s_stall[e];
        step();
        if (!s_stall[e]) idx++;
        check($sformatf("d3_e%0d_valid", e), 32'(bus3.out_valid), 32'(s_valid[e]));
        if (s_valid[e]) begin
          check($sformatf("d3_e%0d_pc", e),   bus3.out_pc,        s_pc[e]);
          check($sformatf("d3_e%0d_tnew", e), 32'(bus3.out_tnew), 32'd0);
        end
      end
    end

    // 6. reset while stalled mid-stream on DEPTH=3
    for (int i = 0; i < 3; i++) begin
      drive3(1, 32'h3100 + 32'(i) * 4, 5'd4, 1, 2'd1, 32'h0);
      bus3.stall = 1'b0;
      step();
    end
    check("pre_rst_valid", 32'(bus3.out_valid), 32'd1);
    check("pre_rst_pc",    bus3.out_pc,         32'h3100);
    bus3.stall = 1'b1;
    reset = 1'b0;
    step();
    check("mid_rst_valid",  32'(bus3.out_valid), 32'd0);
    check("mid_rst_pc",     bus3.out_pc,         32'h3000);
    check("mid_rst1_valid", 32'(bus1.out_valid), 32'd0);
    reset = 1'b1;
    bus3.stall = 1'b0;
    drive3(0, 32'h0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("drain%0d_valid", i), 32'(bus3.out_valid), 32'd0);
      check($sformatf("drain%0d_pc", i),    bus3.out_pc,         32'h3000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
